alu_op_sequencer: RTL

- Command-side initiator that drives the 16-bit ALU top level (ports A, B, alu_fun; responses arith/logic/comp/shift outputs and flags, carry_out).
- Accepts operation requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each operation to the ALU, waits for the flag of the expected result class, and returns one result per command over a valid/ready response interface.
- Sits between a host/controller and the ALU, replacing direct testbench-style stimulus.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_cmd_fifo.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared classes, FSM encoding and class decode for alu_op_sequencer
package alu_seq_pkg;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_COMP  = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    function automatic logic [1:0] fun_class(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_seq_cmd_fifo.sv
// rtl/alu_seq_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module alu_seq_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands, issues them one at a time and returns flagged results
// Optional statistics counters enabled by ALU_SEQ_STATS_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_WIDTH = 16,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_WIDTH-1:0] cmd_a,
    input  logic [ALU_WIDTH-1:0] cmd_b,
    input  logic [3:0]           cmd_fun,
    output logic [ALU_WIDTH-1:0] alu_a,
    output logic [ALU_WIDTH-1:0] alu_b,
    output logic [3:0]           alu_fun,
    input  logic [ALU_WIDTH-1:0] arith_out,
    input  logic [ALU_WIDTH-1:0] logic_out,
    input  logic [ALU_WIDTH-1:0] comp_out,
    input  logic [ALU_WIDTH-1:0] shift_out,
    input  logic                 arith_flag,
    input  logic                 logic_flag,
    input  logic                 comp_flag,
    input  logic                 shift_flag,
    input  logic                 carry_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_WIDTH-1:0] rsp_data,
    output logic                 rsp_carry,
    output logic [1:0]           rsp_class,
    output logic                 rsp_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [7:0]           stat_errs
`endif
);
    localparam int ENTRY_W = 2 * ALU_WIDTH + 4;
    localparam int TMO_W   = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    seq_state_t           state, state_n;
    logic [ALU_WIDTH-1:0] alu_a_n, alu_b_n;
    logic [3:0]           alu_fun_n;
    logic [1:0]           exp_cls, exp_cls_n;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_n;
    logic                 rsp_valid_n, rsp_carry_n, rsp_err_n;
    logic [ALU_WIDTH-1:0] rsp_data_n;
    logic [1:0]           rsp_class_n;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_dout;
    logic                 flag_hit;
    logic [ALU_WIDTH-1:0] hit_data;

    assign cmd_ready = !rst && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    alu_seq_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cmd_a, cmd_b, cmd_fun}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Only the flag of the class we issued counts; other classes are ignored.
    always_comb begin
        flag_hit = 1'b0;
        hit_data = '0;
        case (exp_cls)
            CLS_ARITH: begin flag_hit = arith_flag; hit_data = arith_out; end
            CLS_LOGIC: begin flag_hit = logic_flag; hit_data = logic_out; end
            CLS_COMP:  begin flag_hit = comp_flag;  hit_data = comp_out;  end
            CLS_SHIFT: begin flag_hit = shift_flag; hit_data = shift_out; end
            default:   begin flag_hit = 1'b0;       hit_data = '0;        end
        endcase
    end

    always_comb begin
        state_n     = state;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        alu_fun_n   = alu_fun;
        exp_cls_n   = exp_cls;
        tmo_cnt_n   = tmo_cnt;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        rsp_carry_n = rsp_carry;
        rsp_class_n = rsp_class;
        rsp_err_n   = rsp_err;
        fifo_pop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                      = 1'b1;
                    {alu_a_n, alu_b_n, alu_fun_n} = fifo_dout;
                    exp_cls_n                     = fun_class(fifo_dout[3:0]);
                    state_n                       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_n = '0;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                if (flag_hit) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = hit_data;
                    rsp_carry_n = (exp_cls == CLS_ARITH) && carry_out;
                    rsp_class_n = exp_cls;
                    rsp_err_n   = 1'b0;
                    state_n     = ST_RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_carry_n = 1'b0;
                    rsp_class_n = exp_cls;
                    rsp_err_n   = 1'b1;
                    state_n     = ST_RESP;
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fun   <= '0;
            exp_cls   <= CLS_ARITH;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_class <= CLS_ARITH;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_fun   <= alu_fun_n;
            exp_cls   <= exp_cls_n;
            tmo_cnt   <= tmo_cnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_carry <= rsp_carry_n;
            rsp_class <= rsp_class_n;
            rsp_err   <= rsp_err_n;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_fire;
    assign rsp_fire = (state == ST_RESP) && rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_fire) begin
            if (rsp_err) begin
                if (stat_errs != '1) stat_errs <= stat_errs + 8'd1;
            end else begin
                if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
            end
        end
    end
`endif

endmodule
